// File: rtl/cmult_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cmult_stream                                                 |
// | Description : Streaming complex multiplier, A*B or A*conj(B), 4-stage      |
// |               pipeline with rounding, saturation/wrap and overflow stats.  |
// |               Define CMULT_STREAM_SAT_EN to clamp overflowed components.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+

module cmult_stream #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int P_WIDTH   = 16,
    parameter int SHIFT     = 14,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [A_WIDTH-1:0]   in_ar,
    input  logic signed [A_WIDTH-1:0]   in_ai,
    input  logic signed [B_WIDTH-1:0]   in_br,
    input  logic signed [B_WIDTH-1:0]   in_bi,
    input  logic                        in_conj,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [P_WIDTH-1:0]   out_pr,
    output logic signed [P_WIDTH-1:0]   out_pi,
    output logic                        out_ovf,
    input  logic                        ovf_clr,
    output logic                        ovf_sticky,
    output logic [CNT_WIDTH-1:0]        ovf_cnt
);

    localparam int c_m_w = A_WIDTH + B_WIDTH;
    localparam int c_f_w = A_WIDTH + B_WIDTH + 2;
    // Extended width for limit comparison: always wider than both the
    // shifted sum and the output, so sign extension is lossless.
    localparam int c_e_w = ((P_WIDTH > c_f_w) ? P_WIDTH : c_f_w) + 1;

    localparam logic signed [c_e_w-1:0] c_pmax =
        {{(c_e_w-P_WIDTH+1){1'b0}}, {(P_WIDTH-1){1'b1}}};
    localparam logic signed [c_e_w-1:0] c_pmin = ~c_pmax;

    logic w_en;

    // Stage 1: input capture
    logic                       r_v1;
    logic                       r_cj1;
    logic signed [A_WIDTH-1:0]  r_ar;
    logic signed [A_WIDTH-1:0]  r_ai;
    logic signed [B_WIDTH-1:0]  r_br;
    logic signed [B_WIDTH-1:0]  r_bi;

    // Stage 2: partial products
    logic                       r_v2;
    logic                       r_cj2;
    logic signed [c_m_w-1:0]    r_p_rr;
    logic signed [c_m_w-1:0]    r_p_ii;
    logic signed [c_m_w-1:0]    r_p_ri;
    logic signed [c_m_w-1:0]    r_p_ir;

    // Stage 3: full-precision sum/difference
    logic                       r_v3;
    logic signed [c_f_w-1:0]    r_sum [2];
    logic signed [c_f_w-1:0]    w_sum [2];
    logic signed [c_f_w-1:0]    w_rr;
    logic signed [c_f_w-1:0]    w_ii;
    logic signed [c_f_w-1:0]    w_ri;
    logic signed [c_f_w-1:0]    w_ir;

    // Stage 4: rounded and limited result
    logic                       r_v4;
    logic signed [P_WIDTH-1:0]  r_res [2];
    logic                       r_ovf4;
    logic signed [P_WIDTH-1:0]  w_res [2];
    logic [1:0]                 w_ovf;

    // Overflow statistics
    logic                       w_consume;
    logic                       w_ovf_evt;
    logic                       r_sticky;
    logic [CNT_WIDTH-1:0]       r_cnt;

    assign w_en      = !r_v4 || out_ready;
    assign in_ready  = w_en;

    assign out_valid  = r_v4;
    assign out_pr     = r_res[0];
    assign out_pi     = r_res[1];
    assign out_ovf    = r_ovf4;
    assign ovf_sticky = r_sticky;
    assign ovf_cnt    = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_cj1 <= 1'b0;
            r_ar  <= '0;
            r_ai  <= '0;
            r_br  <= '0;
            r_bi  <= '0;
        end else if (w_en) begin
            r_v1  <= in_valid;
            r_cj1 <= in_conj;
            r_ar  <= in_ar;
            r_ai  <= in_ai;
            r_br  <= in_br;
            r_bi  <= in_bi;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2   <= 1'b0;
            r_cj2  <= 1'b0;
            r_p_rr <= '0;
            r_p_ii <= '0;
            r_p_ri <= '0;
            r_p_ir <= '0;
        end else if (w_en) begin
            r_v2   <= r_v1;
            r_cj2  <= r_cj1;
            r_p_rr <= c_m_w'(r_ar) * c_m_w'(r_br);
            r_p_ii <= c_m_w'(r_ai) * c_m_w'(r_bi);
            r_p_ri <= c_m_w'(r_ar) * c_m_w'(r_bi);
            r_p_ir <= c_m_w'(r_ai) * c_m_w'(r_br);
        end
    end

    assign w_rr = c_f_w'(r_p_rr);
    assign w_ii = c_f_w'(r_p_ii);
    assign w_ri = c_f_w'(r_p_ri);
    assign w_ir = c_f_w'(r_p_ir);

    always_comb begin
        w_sum[0] = w_rr - w_ii;
        w_sum[1] = w_ri + w_ir;
        if (r_cj2) begin
            w_sum[0] = w_rr + w_ii;
            w_sum[1] = w_ir - w_ri;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v3     <= 1'b0;
            r_sum[0] <= '0;
            r_sum[1] <= '0;
        end else if (w_en) begin
            r_v3     <= r_v2;
            r_sum[0] <= w_sum[0];
            r_sum[1] <= w_sum[1];
        end
    end

    // Component 0 is the real part, component 1 the imaginary part.
    for (genvar k = 0; k < 2; k++) begin : g_comp
        logic signed [c_f_w-1:0]   w_rnd;
        logic signed [c_f_w-1:0]   w_sh;
        logic signed [c_e_w-1:0]   w_ext;
        logic signed [P_WIDTH-1:0] w_wrap;

        if (SHIFT > 0) begin : g_round
            localparam logic signed [c_f_w-1:0] c_half =
                {{(c_f_w-1){1'b0}}, 1'b1} <<< (SHIFT-1);
            assign w_rnd = r_sum[k] + c_half;
        end else begin : g_noround
            assign w_rnd = r_sum[k];
        end

        assign w_sh   = w_rnd >>> SHIFT;
        assign w_ext  = c_e_w'(w_sh);
        assign w_wrap = w_ext[P_WIDTH-1:0];
        // When the output is at least as wide as the shifted value this
        // comparison can never be true, so no overflow is ever reported.
        assign w_ovf[k] = (w_ext > c_pmax) || (w_ext < c_pmin);

`ifdef CMULT_STREAM_SAT_EN
        assign w_res[k] = !w_ovf[k] ? w_wrap :
                          (w_ext[c_e_w-1] ? c_pmin[P_WIDTH-1:0] : c_pmax[P_WIDTH-1:0]);
`else
        assign w_res[k] = w_wrap;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v4     <= 1'b0;
            r_ovf4   <= 1'b0;
            r_res[0] <= '0;
            r_res[1] <= '0;
        end else if (w_en) begin
            r_v4     <= r_v3;
            r_ovf4   <= r_v3 && (|w_ovf);
            r_res[0] <= w_res[0];
            r_res[1] <= w_res[1];
        end
    end

    assign w_consume = r_v4 && out_ready;
    assign w_ovf_evt = w_consume && r_ovf4;

    // A clear coinciding with an overflowed consumption counts that sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (ovf_clr) begin
            r_sticky <= w_ovf_evt;
            r_cnt    <= w_ovf_evt ? CNT_WIDTH'(1) : '0;
        end else if (w_ovf_evt) begin
            r_sticky <= 1'b1;
            if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cmult_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cmult_stream                                              |
// | Description : Scoreboard bench for cmult_stream at default parameters.     |
// |               Honours CMULT_STREAM_SAT_EN for expected overflow values.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+

module tb_cmult_stream;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_ar, in_ai, in_br, in_bi;
    logic               in_conj;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_pr, out_pi;
    logic               out_ovf;
    logic               ovf_clr;
    logic               ovf_sticky;
    logic [15:0]        ovf_cnt;

    always #5 clk = ~clk;

    cmult_stream #(
        .A_WIDTH(16), .B_WIDTH(16), .P_WIDTH(16), .SHIFT(14), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ar(in_ar), .in_ai(in_ai), .in_br(in_br), .in_bi(in_bi),
        .in_conj(in_conj),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pr(out_pr), .out_pi(out_pi), .out_ovf(out_ovf),
        .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky), .ovf_cnt(ovf_cnt)
    );

    typedef struct {
        int    pr;
        int    pi;
        bit    ovf;
        int    cyc;
        bit    chk_lat;
        string name;
    } exp_t;

    exp_t q[$];
    int total   = 0;
    int bad     = 0;
    int cyc     = 0;
    int exp_cnt = 0;
    int n_cons  = 0;
    int rdy_mode = 0;

`ifdef CMULT_STREAM_SAT_EN
    localparam int OVF_PR = 32767;
`else
    localparam int OVF_PR = 0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    function automatic void lim(input longint v, output int r, output bit o);
        longint      s;
        logic [15:0] w;
        s = (v + 64'sd8192) >>> 14;
        o = (s > 32767) || (s < -32768);
        w = s[15:0];
`ifdef CMULT_STREAM_SAT_EN
        if (o) r = (s > 0) ? 32767 : -32768;
        else   r = int'($signed(w));
`else
        r = int'($signed(w));
`endif
    endfunction

    function automatic void model(input int ar, input int ai, input int br, input int bi,
                                  input bit cj, output int pr, output int pi, output bit ov);
        longint re, im;
        bit     o1, o2;
        if (cj) begin
            re = longint'(ar) * br + longint'(ai) * bi;
            im = longint'(ai) * br - longint'(ar) * bi;
        end else begin
            re = longint'(ar) * br - longint'(ai) * bi;
            im = longint'(ar) * bi + longint'(ai) * br;
        end
        lim(re, pr, o1);
        lim(im, pi, o2);
        ov = o1 | o2;
    endfunction

    // Ready pattern: 0 = always ready, 1 = low 3 of every 5 cycles, 2 = never ready.
    initial begin : ready_drv
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (ph < 2);
                default: out_ready = 1'b0;
            endcase
            ph = (ph == 4) ? 0 : ph + 1;
        end
    end

    initial begin : monitor
        exp_t               e;
        logic signed [15:0] h_pr, h_pi;
        logic               h_ovf;
        bit                 held;
        held = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held = 0;
            end else begin
                if (held) begin
                    check("stall_valid", longint'(out_valid), 1);
                    check("stall_pr", longint'(out_pr), longint'(h_pr));
                    check("stall_pi", longint'(out_pi), longint'(h_pi));
                    check("stall_ovf", longint'(out_ovf), longint'(h_ovf));
                end
                held = 0;
                if (out_valid && !out_ready) begin
                    held  = 1;
                    h_pr  = out_pr;
                    h_pi  = out_pi;
                    h_ovf = out_ovf;
                end else if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got pr=%0d pi=%0d, want no output",
                                 out_pr, out_pi);
                    end else begin
                        e = q.pop_front();
                        check({e.name, "_pr"}, longint'(out_pr), longint'(e.pr));
                        check({e.name, "_pi"}, longint'(out_pi), longint'(e.pi));
                        check({e.name, "_ovf"}, longint'(out_ovf), longint'(e.ovf));
                        if (e.chk_lat) check({e.name, "_latency"}, longint'(cyc - e.cyc), 4);
                        if (e.ovf) exp_cnt++;
                        n_cons++;
                    end
                end
            end
        end
    end

    task automatic send(input int ar, input int ai, input int br, input int bi, input bit cj,
                        input int pr, input int pi, input bit ov, input bit lat,
                        input string nm);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_ar = 16'(ar);
        in_ai = 16'(ai);
        in_br = 16'(br);
        in_bi = 16'(bi);
        in_conj = cj;
        #1;
        while (!in_ready) begin
            if (n >= 50) begin
                total++;
                bad++;
                $display("FAIL %s_accept: got in_ready=0 for 50 cycles, want accept", nm);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
            n++;
        end
        e.pr = pr; e.pi = pi; e.ovf = ov; e.cyc = cyc; e.chk_lat = lat; e.name = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_drain: got %0d pending, want 0", nm, q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        int  ar, ai, br, bi, pr, pi, n, cons0;
        bit  cj, ov;
        rst = 1'b1;
        in_valid = 1'b0;
        in_ar = '0; in_ai = '0; in_br = '0; in_bi = '0;
        in_conj = 1'b0;
        ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_pr", longint'(out_pr), 0);
        check("rst_out_pi", longint'(out_pi), 0);
        check("rst_out_ovf", longint'(out_ovf), 0);
        check("rst_sticky", longint'(ovf_sticky), 0);
        check("rst_cnt", longint'(ovf_cnt), 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", longint'(in_ready), 1);

        send(16384, 0, 8192, 4096, 0, 8192, 4096, 0, 1, "basic");
        send(0, 16384, 0, 16384, 0, -16384, 0, 0, 1, "jj_mul");
        send(0, 16384, 0, 16384, 1, 16384, 0, 0, 1, "jj_conj");
        send(1, 0, 8192, 0, 0, 1, 0, 0, 1, "round_half");
        send(1, 0, 8191, 0, 0, 0, 0, 0, 1, "round_below");
        drain("directed");
        check("cnt_after_clean", longint'(ovf_cnt), 0);
        check("sticky_after_clean", longint'(ovf_sticky), 0);

        send(-32768, 0, -32768, 0, 0, OVF_PR, 0, 1, 1, "ovf1");
        drain("ovf1");
        check("cnt_ovf1", longint'(ovf_cnt), 1);
        check("sticky_ovf1", longint'(ovf_sticky), 1);
        send(-32768, 0, -32768, 0, 0, OVF_PR, 0, 1, 1, "ovf2");
        drain("ovf2");
        check("cnt_ovf2", longint'(ovf_cnt), 2);

        // Clear in the very cycle the overflowed sample is consumed.
        send(-32768, 0, -32768, 0, 0, OVF_PR, 0, 1, 1, "ovf3");
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        check("clr_wait_valid", longint'(out_valid), 1);
        ovf_clr = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        ovf_clr = 1'b0;
        drain("ovf3");
        check("cnt_clr_coincident", longint'(ovf_cnt), 1);
        check("sticky_clr_coincident", longint'(ovf_sticky), 1);

        @(negedge clk);
        ovf_clr = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        ovf_clr = 1'b0;
        #1;
        check("cnt_clr_plain", longint'(ovf_cnt), 0);
        check("sticky_clr_plain", longint'(ovf_sticky), 0);

        rdy_mode = 1;
        cons0 = n_cons;
        for (int i = 0; i < 100; i++) begin
            ar = int'($urandom_range(65535)) - 32768;
            ai = int'($urandom_range(65535)) - 32768;
            br = int'($urandom_range(65535)) - 32768;
            bi = int'($urandom_range(65535)) - 32768;
            cj = 1'($urandom_range(1));
            model(ar, ai, br, bi, cj, pr, pi, ov);
            send(ar, ai, br, bi, cj, pr, pi, ov, 0, "stream");
        end
        drain("stream");
        rdy_mode = 0;
        check("stream_count", longint'(n_cons - cons0), 100);
        check("stream_ovf_cnt", longint'(ovf_cnt), longint'(exp_cnt));
        check("stream_sticky", longint'(ovf_sticky), longint'(exp_cnt != 0));

        // Reset with samples in flight and the output stalled.
        rdy_mode = 2;
        @(negedge clk);
        send(100, 0, 16384, 0, 0, 100, 0, 0, 0, "flight0");
        send(200, 0, 16384, 0, 0, 200, 0, 0, 0, "flight1");
        send(300, 0, 16384, 0, 0, 300, 0, 0, 0, "flight2");
        repeat (3) @(negedge clk);
        check("flight_valid", longint'(out_valid), 1);
        #3;
        rst = 1'b1;
        q.delete();
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_out_pr", longint'(out_pr), 0);
        check("midrst_in_ready", longint'(in_ready), 1);
        check("midrst_cnt", longint'(ovf_cnt), 0);
        check("midrst_sticky", longint'(ovf_sticky), 0);
        exp_cnt = 0;
        @(negedge clk);
        rdy_mode = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("post_rst_idle", longint'(out_valid), 0);
        send(-5, 7, 16384, 0, 0, -5, 7, 0, 1, "post_rst");
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
